// File: rtl/data_memory_multi_delay_if.sv
// Load/store request bus for the variable-latency data memory.
// A request is taken on a rising edge where ready=1 and rd_en|wr_en; rvalid/err are single-cycle completion pulses.
interface data_memory_multi_delay_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      rd_en;
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rvalid;
    logic                      err;

    modport master (
        output rd_en, wr_en, addr, wdata, wstrb,
        input  ready, rdata, rvalid, err
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata, wstrb,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/data_memory_multi_delay.sv
// Variable-latency, byte-strobed data memory seen by the MEM stage.
// One transaction in flight at a time; inputs are latched at acceptance and ignored while busy.
module data_memory_multi_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int RD_DELAY   = 4,
    parameter int WR_DELAY   = 4,
    parameter int BYTE_ADDR  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    data_memory_multi_delay_if.slave  bus,
    output logic [1:0]                dbg_state
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFFSET    = (BYTE_ADDR != 0) ? $clog2(BYTES) : 0;
    localparam int MAX_DELAY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READING = 2'd1,
        WRITING = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      wstrb_q, wstrb_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] ram_word [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    assign word_addr = bus.addr >> OFFSET;
    assign rd_word   = ram_word[idx_q];

    // Storage is never reset so a write survives a later reset; power-up image is RAM[i]=i.
    for (genvar i = 0; i < RAM_DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(i);
        logic [DATA_WIDTH-1:0] word_d;

        always_comb begin
            word_d = word_q;
            if (ram_we && (idx_q == IDX_W'(i))) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wstrb_q[b]) word_d[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            word_q <= word_d;
        end

        assign ram_word[i] = word_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        ready_d  = ready_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q && (bus.rd_en || bus.wr_en)) begin
                    idx_d   = word_addr[IDX_W-1:0];
                    oor_d   = (word_addr >= ADDR_WIDTH'(RAM_DEPTH));
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                    ready_d = 1'b0;
                    // A simultaneous write is dropped: the read takes the slot.
                    if (bus.rd_en) begin
                        state_d = READING;
                        cnt_d   = CNT_W'(RD_DELAY - 1);
                    end else begin
                        state_d = WRITING;
                        cnt_d   = CNT_W'(WR_DELAY - 1);
                    end
                end
            end
            READING, WRITING: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    err_d   = oor_q;
                    if (state_q == READING) begin
                        rvalid_d = 1'b1;
                        rdata_d  = oor_q ? '0 : rd_word;
                    end else begin
                        ram_we = !oor_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_data_memory_multi_delay.sv
// Bench for data_memory_multi_delay: instance A (4/4 delay, byte addressed, 256 words)
// and instance B (2/1 delay, word addressed, 16 words) against a word-array model.
module tb_data_memory_multi_delay;
    localparam int RDA = 4;
    localparam int WRA = 4;
    localparam int RDB = 2;
    localparam int WRB = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_multi_delay_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
    data_memory_multi_delay_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    data_memory_multi_delay #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256),
        .RD_DELAY(RDA), .WR_DELAY(WRA), .BYTE_ADDR(1)
    ) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave), .dbg_state(dbg_a));

    data_memory_multi_delay #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(16),
        .RD_DELAY(RDB), .WR_DELAY(WRB), .BYTE_ADDR(0)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave), .dbg_state(dbg_b));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_rv;
        logic        exp_err;
    } vec_t;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [16];
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [31:0] exp_q [$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (w == 0) begin
            ifa.rd_en = rd; ifa.wr_en = wr; ifa.addr = a; ifa.wdata = d; ifa.wstrb = s;
        end else begin
            ifb.rd_en = rd; ifb.wr_en = wr; ifb.addr = a; ifb.wdata = d; ifb.wstrb = s;
        end
    endtask

    task automatic sample(input int w, output logic rdy, output logic rv, output logic er,
                          output logic [31:0] rdv);
        if (w == 0) begin
            rdy = ifa.ready; rv = ifa.rvalid; er = ifa.err; rdv = ifa.rdata;
        end else begin
            rdy = ifb.ready; rv = ifb.rvalid; er = ifb.err; rdv = ifb.rdata;
        end
    endtask

    // Enters and leaves at a falling edge. Expected values come from the word model
    // unless a table row supplies them; the model is updated either way.
    task automatic run(input int w, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit noise, input string tag,
                       input bit use_tab, input logic [31:0] t_rdata, input logic t_rv,
                       input logic t_err, output int acc);
        logic [31:0] wi;
        bit          oor;
        logic [31:0] e_rdata;
        logic        e_rv;
        logic        e_err;
        logic        rdy;
        logic        rv;
        logic        er;
        logic [31:0] rdv;
        logic [31:0] e_pop;
        int          busy;
        bit          pulse_bad;
        int          delay;
        int          waits;

        wi  = (w == 0) ? (a >> 2) : a;
        oor = (w == 0) ? (wi >= 32'd256) : (wi >= 32'd16);
        e_rv  = rd;
        e_err = oor;
        if (rd) e_rdata = oor ? 32'h0 : ((w == 0) ? mem_a[wi[7:0]] : mem_b[wi[3:0]]);
        else    e_rdata = (w == 0) ? last_a : last_b;
        if (use_tab) begin
            e_rdata = t_rdata; e_rv = t_rv; e_err = t_err;
        end
        delay = rd ? ((w == 0) ? RDA : RDB) : ((w == 0) ? WRA : WRB);

        sample(w, rdy, rv, er, rdv);
        waits = 0;
        while (!rdy && waits < 20) begin
            @(negedge clk);
            sample(w, rdy, rv, er, rdv);
            waits++;
        end
        check({tag, " idle_before"}, 32'(rdy), 32'd1);

        drive(w, rd, wr, a, d, s);
        @(posedge clk);
        acc = int'($time / 10);
        if (rd) exp_q.push_back(e_rdata);

        busy = 0;
        pulse_bad = 1'b0;
        @(negedge clk);
        sample(w, rdy, rv, er, rdv);
        while (!rdy && busy < 20) begin
            busy++;
            if (rv || er) pulse_bad = 1'b1;
            if (noise) drive(w, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
            else       drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            sample(w, rdy, rv, er, rdv);
        end
        drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        check({tag, " ready_low_cycles"}, 32'(busy), 32'(delay));
        check({tag, " pulses_clear_while_busy"}, 32'(pulse_bad), 32'd0);
        check({tag, " rvalid"}, 32'(rv), 32'(e_rv));
        check({tag, " err"}, 32'(er), 32'(e_err));
        if (rd) begin
            e_pop = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            check({tag, " rdata"}, rdv, e_pop);
            if (w == 0) last_a = e_rdata; else last_b = e_rdata;
        end else begin
            check({tag, " rdata_held"}, rdv, e_rdata);
        end

        if (!rd && wr && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (w == 0) mem_a[wi[7:0]][8*b +: 8] = d[8*b +: 8];
                    else        mem_b[wi[3:0]][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab [17];
        logic        rdy;
        logic        rv;
        logic        er;
        logic [31:0] rdv;
        int          acc;
        int          t [6];
        logic [31:0] a;
        int          op;

        for (int i = 0; i < 256; i++) mem_a[i] = 32'(i);
        for (int i = 0; i < 16; i++)  mem_b[i] = 32'(i);
        last_a = 32'h0;
        last_b = 32'h0;

        tab[0]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'h00000004, 1'b1, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 32'h14,       32'hDEADBEEF, 4'hF, 32'h00000004, 1'b0, 1'b0};
        tab[2]  = '{1'b1, 1'b0, 32'h14,       32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 1'b1, 32'h14,       32'h11112222, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0};
        tab[4]  = '{1'b1, 1'b0, 32'h14,       32'h0,        4'h0, 32'hDEAD2222, 1'b1, 1'b0};
        tab[5]  = '{1'b1, 1'b1, 32'h08,       32'hFFFFFFFF, 4'hF, 32'h00000002, 1'b1, 1'b0};
        tab[6]  = '{1'b1, 1'b0, 32'h08,       32'h0,        4'h0, 32'h00000002, 1'b1, 1'b0};
        tab[7]  = '{1'b1, 1'b0, 32'h400,      32'h0,        4'h0, 32'h00000000, 1'b1, 1'b1};
        tab[8]  = '{1'b0, 1'b1, 32'h400,      32'h5,        4'hF, 32'h00000000, 1'b0, 1'b1};
        tab[9]  = '{1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h00000000, 1'b1, 1'b0};
        tab[10] = '{1'b1, 1'b0, 32'h13,       32'h0,        4'h0, 32'h00000004, 1'b1, 1'b0};
        tab[11] = '{1'b0, 1'b1, 32'h30,       32'hFFFFFFFF, 4'h0, 32'h00000004, 1'b0, 1'b0};
        tab[12] = '{1'b1, 1'b0, 32'h30,       32'h0,        4'h0, 32'h0000000C, 1'b1, 1'b0};
        tab[13] = '{1'b1, 1'b0, 32'h3FF,      32'h0,        4'h0, 32'h000000FF, 1'b1, 1'b0};
        tab[14] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h00000000, 1'b1, 1'b1};
        tab[15] = '{1'b0, 1'b1, 32'h3FC,      32'hA5A5A5A5, 4'hC, 32'h00000000, 1'b0, 1'b0};
        tab[16] = '{1'b1, 1'b0, 32'h3FC,      32'h0,        4'h0, 32'hA5A500FF, 1'b1, 1'b0};

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w, rdy, rv, er, rdv);
            check($sformatf("reset%0d ready", w), 32'(rdy), 32'd1);
            check($sformatf("reset%0d rvalid", w), 32'(rv), 32'd0);
            check($sformatf("reset%0d err", w), 32'(er), 32'd0);
            check($sformatf("reset%0d rdata", w), rdv, 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run(0, tab[i].rd, tab[i].wr, tab[i].addr, tab[i].wdata, tab[i].wstrb, 1'b0,
                $sformatf("vec%0d", i), 1'b1, tab[i].exp_rdata, tab[i].exp_rv, tab[i].exp_err, acc);
        end

        // Reset two cycles into a write must abort it and leave RAM untouched.
        drive(0, 1'b0, 1'b1, 32'h20, 32'hCAFE0000, 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 sample(0, rdy, rv, er, rdv);
        check("abort ready", 32'(rdy), 32'd1);
        check("abort rvalid", 32'(rv), 32'd0);
        check("abort err", 32'(er), 32'd0);
        check("abort rdata", rdv, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        last_a = 32'h0;
        last_b = 32'h0;
        exp_q.delete();
        run(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "abort_read", 1'b1, 32'h8, 1'b1, 1'b0, acc);
        run(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "survive_read", 1'b1, 32'hDEAD2222, 1'b1, 1'b0, acc);

        // Back-to-back on B with bus noise while busy; spacing is DELAY+1.
        run(1, 1'b1, 1'b0, 32'd3,  32'h0, 4'h0, 1'b1, "b_rd3",  1'b1, 32'd3,  1'b1, 1'b0, t[0]);
        run(1, 1'b1, 1'b0, 32'd7,  32'h0, 4'h0, 1'b1, "b_rd7",  1'b1, 32'd7,  1'b1, 1'b0, t[1]);
        run(1, 1'b1, 1'b0, 32'd15, 32'h0, 4'h0, 1'b1, "b_rd15", 1'b1, 32'd15, 1'b1, 1'b0, t[2]);
        run(1, 1'b0, 1'b1, 32'd5,  32'hAABBCCDD, 4'hF, 1'b0, "b_wr5", 1'b1, 32'd15, 1'b0, 1'b0, t[3]);
        run(1, 1'b1, 1'b0, 32'd5,  32'h0, 4'h0, 1'b0, "b_rd5",  1'b1, 32'hAABBCCDD, 1'b1, 1'b0, t[4]);
        run(1, 1'b1, 1'b0, 32'd16, 32'h0, 4'h0, 1'b0, "b_rd16", 1'b1, 32'h0, 1'b1, 1'b1, t[5]);
        check("b spacing rd-rd 1", 32'(t[1] - t[0]), 32'(RDB + 1));
        check("b spacing rd-rd 2", 32'(t[2] - t[1]), 32'(RDB + 1));
        check("b spacing wr-rd", 32'(t[4] - t[3]), 32'(WRB + 1));

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            a  = 32'($urandom_range(0, 270)) * 32'd4 + 32'($urandom_range(0, 3));
            run(0, (op != 1), (op == 1 || op == 2), a, $urandom, 4'($urandom), 1'($urandom),
                $sformatf("rand_a%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, acc);
            op = $urandom_range(0, 3);
            a  = 32'($urandom_range(0, 19));
            run(1, (op != 1), (op == 1 || op == 2), a, $urandom, 4'($urandom), 1'($urandom),
                $sformatf("rand_b%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, acc);
        end

        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w, rdy, rv, er, rdv);
            check($sformatf("final%0d rvalid_cleared", w), 32'(rv), 32'd0);
            check($sformatf("final%0d err_cleared", w), 32'(er), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_multi_delay.md
# data_memory_multi_delay

Parametrised, variable-latency data memory model for the pipeline's load/store path. It is the successor to the fixed-delay single-word memory and adds separate read and write latencies, byte-strobed writes and byte-addressing. It also adds out-of-range error reporting, a registered handshake with a one-cycle read-valid pulse, and a deterministic latency counter that runs only while a transaction is in flight. It sits behind the MEM stage and makes the stall logic see realistic multi-cycle memory latency.

## Interface

- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32: request address width.
- RAM_DEPTH, 256: number of words.
- RD_DELAY, 4: read latency in cycles; minimum 1.
- WR_DELAY, 4: write latency in cycles; minimum 1.
- BYTE_ADDR, 1: 1 means `addr` is a byte address and word index = addr >> log2(DATA_WIDTH/8), with low bits ignored. 0 means `addr` is a word index.

Ports:

- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request, sampled only when ready=1.
- wr_en  in  1  write request, sampled only when ready=1.
- addr  in  ADDR_WIDTH  request address.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte-write enables; bit b covers wdata[8b+7:8b].
- ready  out  1  registered; 1 = idle and able to accept a request.
- rdata  out  DATA_WIDTH  registered read data; holds its last value between reads.
- rvalid  out  1  one-cycle pulse; rdata updated by a read completion.
- err  out  1  one-cycle pulse at completion of an out-of-range transaction.

## Operation

- States: IDLE, READING, WRITING.
- Reset values: state IDLE, ready=1, rvalid=0, err=0, rdata=0, counter=0. RAM contents are not reset.
- RAM is initialised once at simulation start with RAM[i]=i.
- Acceptance happens at a rising edge with ready=1 and rd_en|wr_en.
  - The block latches the word index, wdata, wstrb and direction.
  - It loads the counter with DELAY-1, using RD_DELAY or WR_DELAY according to the direction.
  - It moves to READING or WRITING and sets ready=0.
- If rd_en and wr_en are both high, the read wins and the write is dropped silently. No err is raised.
- While the block is busy, each edge either decrements the counter or, if the counter is 0, completes the transaction:
  - state returns to IDLE and ready=1;
  - read completion: rdata=RAM[idx], rvalid=1;
  - write completion: bytes of RAM[idx] with wstrb=1 take the latched wdata; all other bytes are unchanged; rdata is unchanged.
- Requests and input changes during READING/WRITING are ignored. Only the values latched at acceptance are used.
- Out of range means word index >= RAM_DEPTH. Such a transaction takes the full delay, then pulses err=1 at completion.
  - Read: rdata=0 and rvalid=1.
  - Write: no RAM change.
- rvalid and err are cleared on every edge that is not a completion edge.
- Reset mid-transaction aborts the transaction immediately. A pending write is discarded and RAM is untouched.

## Timing

- For a request accepted at edge k, completion is at edge k+DELAY. ready is 0 for exactly DELAY cycles.
- rvalid, err and the new rdata are visible in the cycle after edge k+DELAY. That cycle is IDLE with ready=1, so a request presented there is accepted at edge k+DELAY+1.
- Maximum throughput is one transaction per DELAY+1 cycles.
- Read-after-write: a read accepted on the edge after a write completion returns the written data.
- The counter width is sufficient for max(RD_DELAY,WR_DELAY)-1. The counter never runs in IDLE.
- DELAY=1: completion at edge k+1 and ready is low for a single cycle.

## Test plan

- Reset, then read byte addr 0x10 with RD_DELAY=4. Required: ready low for 4 cycles, then rvalid pulses for 1 cycle with rdata=0x00000004, err=0.
- Write 0xDEADBEEF with wstrb=0xF to addr 0x14 (WR_DELAY=4), then read it back. Required: rdata=0xDEADBEEF. Then write 0x11112222 with wstrb=0x3 and read back. Required: rdata=0xDEAD2222.
- Assert rd_en and wr_en together at addr 0x08 with wdata=0xFFFFFFFF. Required: a read completes with rdata=0x00000002 after RD_DELAY, and a later read still returns 0x00000002.
- Read addr 0x400 (word 256). Required: after 4 cycles, rvalid=1, err=1, rdata=0. Then write 0x5 to 0x400. Required: err pulse after WR_DELAY, and word 0 still reads 0x00000000.
- Start a write of 0xCAFE0000 to 0x20 and drop reset_n two cycles later. Required: ready=1, rvalid=0 and err=0 immediately; a read of 0x20 returns 0x00000008.
- With RD_DELAY=2, toggle addr and rd_en every cycle while busy and issue back-to-back reads. Required: each returns data for the address latched at acceptance, and acceptances are spaced 3 cycles apart.
